vend_credit_ctrl: RTL and testbench

- Sequences the vending machine's credit counter.
- Accepts 1-unit and 2-unit coin pulses into an internal up/down credit register that steps by ±1 or ±2.
- On a valid selection it issues one vend pulse, subtracts the price, then pays out the remaining credit as change, largest step first.
- Sits between the debounced coin/button inputs and the dispense/change actuators and display.

---
 rtl/vend_credit_ctrl.sv | 129 ++++++++++++
 tb/tb_vend_credit_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_ctrl.sv
// Vending machine credit sequencer: accepts coins, vends on select,
// then pays out the remaining credit as change, largest coin first.
module vend_credit_ctrl #(
  parameter int N     = 4,
  parameter int PRICE = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         coin1,
  input  logic         coin2,
  input  logic         select,
  input  logic         cancel,
  output logic [N-1:0] credit,
  output logic         vend,
  output logic         change1,
  output logic         change2,
  output logic         coin_reject,
  output logic         deny,
  output logic         busy
);

  localparam int MAXC = 2**N - 1;

  localparam logic [N-1:0] L_PRICE = N'(PRICE);
  localparam logic [N-1:0] L_MAX1  = N'(MAXC - 1);
  localparam logic [N-1:0] L_MAX2  = N'(MAXC - 2);
  localparam logic [N-1:0] L_ONE   = N'(1);
  localparam logic [N-1:0] L_TWO   = N'(2);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nx;
  logic [N-1:0] r_credit;
  logic [N-1:0] w_credit_nx;
  logic         r_rej;
  logic         w_rej_nx;
  logic         r_deny;
  logic         w_deny_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ACCEPT;
      r_credit <= '0;
      r_rej    <= 1'b0;
      r_deny   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_credit <= w_credit_nx;
      r_rej    <= w_rej_nx;
      r_deny   <= w_deny_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_credit_nx = r_credit;
    w_rej_nx    = 1'b0;
    w_deny_nx   = 1'b0;
    case (r_state)
      ACCEPT: begin
        if (cancel) begin
          w_state_nx = CHANGE;
          w_rej_nx   = coin1 | coin2;
        end else if (select && (r_credit >= L_PRICE)) begin
          w_state_nx = VEND;
          w_rej_nx   = coin1 | coin2;
        end else begin
          w_deny_nx = select;
          // coin2 wins a tie; a simultaneous coin1 is always returned
          if (coin2) begin
            if (r_credit <= L_MAX2) begin
              w_credit_nx = r_credit + L_TWO;
            end else begin
              w_rej_nx = 1'b1;
            end
            if (coin1) begin
              w_rej_nx = 1'b1;
            end
          end else if (coin1) begin
            if (r_credit <= L_MAX1) begin
              w_credit_nx = r_credit + L_ONE;
            end else begin
              w_rej_nx = 1'b1;
            end
          end
        end
      end
      VEND: begin
        w_rej_nx    = coin1 | coin2;
        w_credit_nx = r_credit - L_PRICE;
        if (r_credit != L_PRICE) begin
          w_state_nx = CHANGE;
        end else begin
          w_state_nx = ACCEPT;
        end
      end
      CHANGE: begin
        w_rej_nx = coin1 | coin2;
        if (r_credit >= L_TWO) begin
          w_credit_nx = r_credit - L_TWO;
          if (r_credit == L_TWO) begin
            w_state_nx = ACCEPT;
          end
        end else begin
          w_credit_nx = '0;
          w_state_nx  = ACCEPT;
        end
      end
      default: begin
        w_state_nx  = ACCEPT;
        w_credit_nx = '0;
      end
    endcase
  end

  assign credit      = r_credit;
  assign vend        = (r_state == VEND);
  assign change2     = (r_state == CHANGE) && (r_credit >= L_TWO);
  assign change1     = (r_state == CHANGE) && (r_credit == L_ONE);
  assign coin_reject = r_rej;
  assign deny        = r_deny;
  assign busy        = (r_state != ACCEPT);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl (N=4, PRICE=3).
// Output vector order: {vend, change1, change2, coin_reject, deny, busy}.
module tb_vend_credit_ctrl;

  logic       clk;
  logic       reset;
  logic       coin1;
  logic       coin2;
  logic       select;
  logic       cancel;
  logic [3:0] credit;
  logic       vend;
  logic       change1;
  logic       change2;
  logic       coin_reject;
  logic       deny;
  logic       busy;

  int n_chk;
  int n_err;

  vend_credit_ctrl #(.N(4), .PRICE(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .coin1      (coin1),
    .coin2      (coin2),
    .select     (select),
    .cancel     (cancel),
    .credit     (credit),
    .vend       (vend),
    .change1    (change1),
    .change2    (change2),
    .coin_reject(coin_reject),
    .deny       (deny),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {vend, change1, change2, coin_reject, deny, busy};
  endfunction

  task automatic pulse(input logic c1, input logic c2,
                       input logic sel, input logic can);
    coin1  = c1;
    coin2  = c2;
    select = sel;
    cancel = can;
    @(posedge clk);
    #1;
    coin1  = 1'b0;
    coin2  = 1'b0;
    select = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    coin1 = 1'b0;
    coin2 = 1'b0;
    select = 1'b0;
    cancel = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (credit !== 4'd0) begin
      n_err++;
      $display("FAIL reset_credit: got %0d exp 0", credit);
    end
    n_chk++;
    if (outs() !== 6'b000000) begin
      n_err++;
      $display("FAIL reset_outs: got %b exp 000000", outs());
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_sale();
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    n_chk++;
    if (credit !== 4'd5) begin
      n_err++;
      $display("FAIL sale_load: got %0d exp 5", credit);
    end
    pulse(0, 0, 1, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b100001, 4'd5}) begin
      n_err++;
      $display("FAIL sale_vend: got %b/%0d exp 100001/5", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b001001, 4'd2}) begin
      n_err++;
      $display("FAIL sale_chg2: got %b/%0d exp 001001/2", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd0}) begin
      n_err++;
      $display("FAIL sale_done: got %b/%0d exp 000000/0", outs(), credit);
    end
  endtask

  task automatic test_overflow();
    bit done;
    for (int i = 0; i < 7; i++) pulse(0, 1, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd14}) begin
      n_err++;
      $display("FAIL ovf_load: got %b/%0d exp 000000/14", outs(), credit);
    end
    pulse(0, 1, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000100, 4'd14}) begin
      n_err++;
      $display("FAIL ovf_c2rej: got %b/%0d exp 000100/14", outs(), credit);
    end
    pulse(1, 0, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd15}) begin
      n_err++;
      $display("FAIL ovf_c1acc: got %b/%0d exp 000000/15", outs(), credit);
    end
    pulse(1, 0, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000100, 4'd15}) begin
      n_err++;
      $display("FAIL ovf_c1rej: got %b/%0d exp 000100/15", outs(), credit);
    end
    pulse(0, 0, 0, 1);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (!busy) done = 1'b1;
      else idle();
    end
    n_chk++;
    if (!done || credit !== 4'd0) begin
      n_err++;
      $display("FAIL ovf_drain: got done=%0b credit=%0d exp 1/0",
               done, credit);
    end
  endtask

  task automatic test_deny();
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000010, 4'd2}) begin
      n_err++;
      $display("FAIL deny_pulse: got %b/%0d exp 000010/2", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd2}) begin
      n_err++;
      $display("FAIL deny_clear: got %b/%0d exp 000000/2", outs(), credit);
    end
  endtask

  task automatic test_refund();
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    n_chk++;
    if (credit !== 4'd5) begin
      n_err++;
      $display("FAIL ref_load: got %0d exp 5", credit);
    end
    pulse(0, 0, 0, 1);
    n_chk++;
    if ({outs(), credit} !== {6'b001001, 4'd5}) begin
      n_err++;
      $display("FAIL ref_c1: got %b/%0d exp 001001/5", outs(), credit);
    end
    pulse(1, 0, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b001101, 4'd3}) begin
      n_err++;
      $display("FAIL ref_c2: got %b/%0d exp 001101/3", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b010001, 4'd1}) begin
      n_err++;
      $display("FAIL ref_c3: got %b/%0d exp 010001/1", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd0}) begin
      n_err++;
      $display("FAIL ref_done: got %b/%0d exp 000000/0", outs(), credit);
    end
  endtask

  task automatic test_simultaneous();
    pulse(1, 1, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000100, 4'd2}) begin
      n_err++;
      $display("FAIL sim_coins: got %b/%0d exp 000100/2", outs(), credit);
    end
    pulse(0, 1, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd4}) begin
      n_err++;
      $display("FAIL sim_load: got %b/%0d exp 000000/4", outs(), credit);
    end
    pulse(0, 0, 1, 1);
    n_chk++;
    if ({outs(), credit} !== {6'b001001, 4'd4}) begin
      n_err++;
      $display("FAIL sim_selcan1: got %b/%0d exp 001001/4", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b001001, 4'd2}) begin
      n_err++;
      $display("FAIL sim_selcan2: got %b/%0d exp 001001/2", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd0}) begin
      n_err++;
      $display("FAIL sim_done: got %b/%0d exp 000000/0", outs(), credit);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    n_chk++;
    if ({outs(), credit} !== {6'b001001, 4'd7}) begin
      n_err++;
      $display("FAIL ares_c1: got %b/%0d exp 001001/7", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b001001, 4'd5}) begin
      n_err++;
      $display("FAIL ares_c2: got %b/%0d exp 001001/5", outs(), credit);
    end
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd0}) begin
      n_err++;
      $display("FAIL ares_now: got %b/%0d exp 000000/0", outs(), credit);
    end
    idle();
    reset = 1'b0;
    pulse(1, 0, 0, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd1}) begin
      n_err++;
      $display("FAIL ares_after: got %b/%0d exp 000000/1", outs(), credit);
    end
  endtask

  task automatic test_exact_price();
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 0);
    n_chk++;
    if ({outs(), credit} !== {6'b100001, 4'd3}) begin
      n_err++;
      $display("FAIL exact_vend: got %b/%0d exp 100001/3", outs(), credit);
    end
    idle();
    n_chk++;
    if ({outs(), credit} !== {6'b000000, 4'd0}) begin
      n_err++;
      $display("FAIL exact_done: got %b/%0d exp 000000/0", outs(), credit);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    test_reset();
    test_sale();
    test_overflow();
    test_deny();
    test_refund();
    test_simultaneous();
    test_async_reset();
    test_exact_price();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
